// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, start-bit validation, framing-error flag.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 10416
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RxD,
  output logic [7:0] data,
  output logic       rx_valid,
  output logic       framing_error,
  output logic       busy
);

  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             rxd_meta;
  logic             rxd_s;

  // Two-flop synchroniser; preset to the idle-high line level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= RxD;
      rxd_s    <= rxd_meta;
    end
  end

  // Receive FSM with registered strobes; data only changes on a good stop bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      baud_cnt      <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      data          <= '0;
      rx_valid      <= 1'b0;
      framing_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      rx_valid      <= 1'b0;
      framing_error <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (!rxd_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            if (rxd_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            shift    <= {rxd_s, shift[7:1]};
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            if (rxd_s) begin
              data     <= shift;
              rx_valid <= 1'b1;
              state    <= IDLE;
              busy     <= 1'b0;
            end else begin
              framing_error <= 1'b1;
              state         <= BREAK;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        BREAK: begin
          // Hold here while the line stays low so a break is not re-framed.
          if (rxd_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx using a short bit period and an event scoreboard.
module tb_uart_rx;

  localparam int CLKS = 16;
  localparam int HALF = CLKS / 2;
  // Posedges from the driven falling edge to the cycle the strobe is visible.
  localparam int LAT  = 3 + HALF + 9 * CLKS;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } ev_t;

  logic       clk;
  logic       reset;
  logic       RxD;
  logic [7:0] data;
  logic       rx_valid;
  logic       framing_error;
  logic       busy;

  ev_t exp_q[$];
  int  errors;
  int  checks;
  int  cyc;
  int  frame_start;
  int  last_valid_cyc;
  int  nvalid;
  int  nferr;

  uart_rx #(.CLKS_PER_BIT(CLKS)) dut (
    .clk           (clk),
    .reset         (reset),
    .RxD           (RxD),
    .data          (data),
    .rx_valid      (rx_valid),
    .framing_error (framing_error),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Drive one frame on negedges; stop level held for stop_bits bit times.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_bits);
    frame_start = cyc;
    RxD = 1'b0;
    repeat (CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      repeat (CLKS) @(negedge clk);
    end
    RxD = stop;
    repeat (CLKS * stop_bits) @(negedge clk);
    RxD = 1'b1;
  endtask

  task automatic test_reset;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
    checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL reset_ferr got=%b exp=0", framing_error); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single;
    int n0;
    n0 = nvalid;
    exp_q.push_back('{is_err: 1'b0, data: 8'h55});
    send_frame(8'h55, 1'b1, 1);
    for (int i = 0; i < 4 * CLKS && exp_q.size() != 0; i++) @(negedge clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL single_drain pending=%0d exp=0", exp_q.size()); end
    checks++; if (nvalid - n0 != 1) begin errors++; $display("FAIL single_count got=%0d exp=1", nvalid - n0); end
    checks++;
    if (last_valid_cyc - frame_start != LAT) begin
      errors++; $display("FAIL single_latency got=%0d exp=%0d", last_valid_cyc - frame_start, LAT);
    end
  endtask

  task automatic test_back_to_back;
    int n0;
    n0 = nvalid;
    exp_q.push_back('{is_err: 1'b0, data: 8'h00});
    exp_q.push_back('{is_err: 1'b0, data: 8'hFF});
    send_frame(8'h00, 1'b1, 1);
    send_frame(8'hFF, 1'b1, 1);
    for (int i = 0; i < 4 * CLKS && exp_q.size() != 0; i++) @(negedge clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain pending=%0d exp=0", exp_q.size()); end
    checks++; if (nvalid - n0 != 2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", nvalid - n0); end
    checks++; if (data !== 8'hFF) begin errors++; $display("FAIL b2b_data got=%h exp=FF", data); end
  endtask

  task automatic test_framing;
    int v0, f0;
    v0 = nvalid;
    f0 = nferr;
    // Retained data on the error strobe must still be the last good byte.
    exp_q.push_back('{is_err: 1'b1, data: 8'hFF});
    send_frame(8'hA3, 1'b0, 4);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL break_busy got=%b exp=1", busy); end
    RxD = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_release got=%b exp=0", busy); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ferr_drain pending=%0d exp=0", exp_q.size()); end
    checks++; if (nferr - f0 != 1) begin errors++; $display("FAIL ferr_count got=%0d exp=1", nferr - f0); end
    checks++; if (nvalid != v0) begin errors++; $display("FAIL ferr_novalid got=%0d exp=%0d", nvalid, v0); end
    checks++; if (data !== 8'hFF) begin errors++; $display("FAIL ferr_data got=%h exp=FF", data); end
  endtask

  task automatic test_glitch;
    int v0, f0;
    v0 = nvalid;
    f0 = nferr;
    repeat (4) @(negedge clk);
    RxD = 1'b0;
    repeat (4) @(negedge clk);
    RxD = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy got=%b exp=1", busy); end
    repeat (HALF + 4) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_idle got=%b exp=0", busy); end
    repeat (12 * CLKS) @(negedge clk);
    checks++;
    if (nvalid != v0 || nferr != f0) begin
      errors++; $display("FAIL glitch_quiet valid=%0d ferr=%0d exp=%0d/%0d", nvalid, nferr, v0, f0);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] b;
    int v0;
    b = 8'h3C;
    RxD = 1'b0;
    repeat (CLKS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      RxD = b[i];
      repeat (CLKS) @(negedge clk);
    end
    RxD = b[4];
    repeat (HALF) @(negedge clk);
    reset = 1'b0;
    RxD = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL abort_data got=%h exp=00", data); end
    reset = 1'b1;
    repeat (4) @(negedge clk);
    v0 = nvalid;
    exp_q.push_back('{is_err: 1'b0, data: 8'hC3});
    send_frame(8'hC3, 1'b1, 1);
    for (int i = 0; i < 4 * CLKS && exp_q.size() != 0; i++) @(negedge clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL abort_drain pending=%0d exp=0", exp_q.size()); end
    checks++; if (nvalid - v0 != 1) begin errors++; $display("FAIL abort_count got=%0d exp=1", nvalid - v0); end
    checks++; if (data !== 8'hC3) begin errors++; $display("FAIL abort_data_c3 got=%h exp=C3", data); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc = 0;
    nvalid = 0;
    nferr = 0;
    last_valid_cyc = 0;
    frame_start = 0;
    reset = 1'b0;
    RxD = 1'b1;

    fork
      // Scoreboard monitor: pops and compares an expected event on every strobe.
      forever begin
        ev_t e;
        @(negedge clk);
        if (reset) begin
          if (rx_valid && framing_error) begin
            checks++; errors++;
            $display("FAIL both_strobes valid=%b ferr=%b exp=not both", rx_valid, framing_error);
          end
          if (rx_valid) begin
            nvalid++;
            last_valid_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
              errors++; $display("FAIL unexpected_valid data=%h exp=none", data);
            end else begin
              e = exp_q.pop_front();
              if (e.is_err !== 1'b0 || data !== e.data) begin
                errors++; $display("FAIL valid_data got=%h exp=%h exp_err=%b", data, e.data, e.is_err);
              end
            end
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL valid_busy got=%b exp=0", busy); end
          end
          if (framing_error) begin
            nferr++;
            checks++;
            if (exp_q.size() == 0) begin
              errors++; $display("FAIL unexpected_ferr data=%h exp=none", data);
            end else begin
              e = exp_q.pop_front();
              if (e.is_err !== 1'b1 || data !== e.data) begin
                errors++; $display("FAIL ferr_event data=%h exp=%h exp_err=%b", data, e.data, e.is_err);
              end
            end
          end
        end
      end
      begin
        #1000000;
        $display("FAIL watchdog cyc=%0d exp=finish", cyc);
        $fatal(1, "timeout");
      end
    join_none

    repeat (3) @(negedge clk);
    reset = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_framing();
    test_glitch();
    test_reset_mid_frame();
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
